urt_rx_param: RTL and testbench

- Parametrised UART receiver. Generalises the fixed 8-bit RX with configurable data width, prescale range, one or two stop bits, majority-vote sampling and explicit error flags.
- Sits behind the RX pin, in front of the register/FIFO layer. Outputs a parallel word with a one-cycle valid pulse, plus parity/stop error strobes.

---
 rtl/urt_rx_param.sv | 187 ++++++++++++++++++
 tb/tb_urt_rx_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/urt_rx_param.sv
// Parametrised UART receiver: DATA_WIDTH data bits, optional parity, 1/2 stop bits, 2-of-3 majority sampling.
// Build option: define URT_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer (adds 2 cycles of latency).
module urt_rx_param #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      busy
);

    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [PRESCALE_WIDTH-1:0] ONE     = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] MIN_PRE = PRESCALE_WIDTH'(4);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic rx;

`ifdef URT_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx = sync_q[1];
`else
    assign rx = RX_IN;
`endif

    state_t                    state;
    state_t                    eval_state;
    logic [PRESCALE_WIDTH-1:0] cfg_pre;
    logic                      cfg_par_en;
    logic                      cfg_par_typ;
    logic                      cfg_stop2;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BW-1:0]             bit_cnt;
    logic                      stop_idx;
    logic                      s0, s1, s2;
    logic                      eval_pending;
    logic                      eval_final;
    logic [DATA_WIDTH-1:0]     shreg;
    logic                      par_flag;
    logic                      stp_flag;

    logic [PRESCALE_WIDTH-1:0] half;
    logic [PRESCALE_WIDTH-1:0] smp_lo;
    logic [PRESCALE_WIDTH-1:0] smp_hi;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic                      edge_last;
    logic                      maj;

    always_comb begin
        half      = cfg_pre >> 1;
        smp_lo    = half - ONE;
        smp_hi    = half + ONE;
        last_edge = cfg_pre - ONE;
        edge_last = (edge_cnt == last_edge);
        maj       = (s0 & s1) | (s0 & s2) | (s1 & s2);
    end

    // The majority is evaluated one cycle after the third sample through eval_pending/eval_state,
    // so at the smallest prescale the evaluation may land in the first cycle of the following bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            eval_state   <= IDLE;
            cfg_pre      <= '0;
            cfg_par_en   <= 1'b0;
            cfg_par_typ  <= 1'b0;
            cfg_stop2    <= 1'b0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            stop_idx     <= 1'b0;
            s0           <= 1'b0;
            s1           <= 1'b0;
            s2           <= 1'b0;
            eval_pending <= 1'b0;
            eval_final   <= 1'b0;
            shreg        <= '0;
            par_flag     <= 1'b0;
            stp_flag     <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state == IDLE) begin
                if (!rx && (Prescale >= MIN_PRE)) begin
                    state        <= START;
                    busy         <= 1'b1;
                    cfg_pre      <= Prescale;
                    cfg_par_en   <= PAR_EN;
                    cfg_par_typ  <= PAR_TYP;
                    cfg_stop2    <= STOP2;
                    edge_cnt     <= ONE;
                    bit_cnt      <= '0;
                    stop_idx     <= 1'b0;
                    par_flag     <= 1'b0;
                    stp_flag     <= 1'b0;
                    eval_pending <= 1'b0;
                end
            end else begin
                edge_cnt <= edge_last ? '0 : edge_cnt + ONE;

                if (edge_cnt == smp_lo) s0 <= rx;
                if (edge_cnt == half)   s1 <= rx;
                if (edge_cnt == smp_hi) begin
                    s2           <= rx;
                    eval_pending <= 1'b1;
                    eval_state   <= state;
                    eval_final   <= (state == STOP) && (stop_idx == cfg_stop2);
                end else begin
                    eval_pending <= 1'b0;
                end

                if (edge_last) begin
                    case (state)
                        START: state <= DATA;
                        DATA: begin
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= cfg_par_en ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_ONE;
                            end
                        end
                        PARITY: state <= STOP;
                        STOP:   stop_idx <= 1'b1;
                        default: ;
                    endcase
                end

                // Evaluation outcomes take priority over the bit-boundary transitions above.
                if (eval_pending) begin
                    case (eval_state)
                        START: begin
                            if (maj) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        DATA: shreg <= {maj, shreg[DATA_WIDTH-1:1]};
                        PARITY: begin
                            if (maj != ((^shreg) ^ cfg_par_typ)) par_flag <= 1'b1;
                        end
                        STOP: begin
                            if (!maj) stp_flag <= 1'b1;
                            if (eval_final) begin
                                P_DATA     <= shreg;
                                data_valid <= maj && !stp_flag && !par_flag;
                                par_err    <= par_flag;
                                stp_err    <= stp_flag || !maj;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_urt_rx_param.sv
// Scoreboard bench for urt_rx_param: an 8-bit and a 5-bit instance, expected frames queued at start-bit time.
module tb_urt_rx_param;

`ifdef URT_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    typedef struct {
        logic [2:0] flags;   // {data_valid, par_err, stp_err}
        logic [8:0] data;
        int         due;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop2 = 1'b0;
    logic [5:0] prescale = 6'd8;

    logic [7:0] p_data_a;
    logic       dv_a, pe_a, se_a, busy_a;
    logic [4:0] p_data_b;
    logic       dv_b, pe_b, se_b, busy_b;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    urt_rx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) u_dut_a (
        .CLK(CLK), .RST(RST), .RX_IN(rx_a), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(prescale), .P_DATA(p_data_a), .data_valid(dv_a),
        .par_err(pe_a), .stp_err(se_a), .busy(busy_a)
    );

    urt_rx_param #(.DATA_WIDTH(5), .PRESCALE_WIDTH(6)) u_dut_b (
        .CLK(CLK), .RST(RST), .RX_IN(rx_b), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .STOP2(stop2), .Prescale(prescale), .P_DATA(p_data_b), .data_valid(dv_b),
        .par_err(pe_b), .stp_err(se_b), .busy(busy_b)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Pulses from the DUTs are matched in order against the queued expectations.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (!RST) begin
            if (dv_a || pe_a || se_a) begin
                if (q_a.size() == 0) begin
                    check("a_spurious", {29'd0, dv_a, pe_a, se_a}, 32'd0);
                end else begin
                    e = q_a.pop_front();
                    check("a_flags", {29'd0, dv_a, pe_a, se_a}, {29'd0, e.flags});
                    check("a_data", {24'd0, p_data_a}, {23'd0, e.data});
                    check("a_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (dv_b || pe_b || se_b) begin
                if (q_b.size() == 0) begin
                    check("b_spurious", {29'd0, dv_b, pe_b, se_b}, 32'd0);
                end else begin
                    e = q_b.pop_front();
                    check("b_flags", {29'd0, dv_b, pe_b, se_b}, {29'd0, e.flags});
                    check("b_data", {27'd0, p_data_b}, {23'd0, e.data});
                    check("b_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge that ends the last bit.
    task automatic drive_bits(input logic [15:0] line, input int nbits, input int p, input bit b);
        for (int i = 0; i < nbits; i++) begin
            if (b) rx_b = line[i];
            else   rx_a = line[i];
            repeat (p) @(negedge CLK);
        end
    endtask

    task automatic frame_raw(input logic [15:0] line, input int nbits, input int p, input bit b,
                             input logic [2:0] flags, input logic [8:0] data);
        exp_t e;
        e.flags = flags;
        e.data  = data;
        e.due   = cyc + p * (nbits - 1) + p / 2 + 3 + SYNC_LAT;
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
        drive_bits(line, nbits, p, b);
    endtask

    task automatic frame(input logic [8:0] data, input int dw, input int p, input bit pe,
                         input bit pt, input bit s2, input bit flip_par, input logic [1:0] bad_stop,
                         input bit b);
        logic [15:0] line;
        logic        par;
        logic        bad_any;
        int          n;
        line = '1;
        n = 0;
        par = pt;
        line[n] = 1'b0;
        n++;
        for (int i = 0; i < dw; i++) begin
            line[n] = data[i];
            par = par ^ data[i];
            n++;
        end
        if (pe) begin
            line[n] = par ^ flip_par;
            n++;
        end
        line[n] = ~bad_stop[0];
        n++;
        bad_any = bad_stop[0];
        if (s2) begin
            line[n] = ~bad_stop[1];
            n++;
            bad_any = bad_any | bad_stop[1];
        end
        par_en   = pe;
        par_typ  = pt;
        stop2    = s2;
        prescale = 6'(p);
        frame_raw(line, n, p, b,
                  {!(pe && flip_par) && !bad_any, pe && flip_par, bad_any}, data);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        repeat (3) @(negedge CLK);
        check("rst_pdata_a", {24'd0, p_data_a}, 32'd0);
        check("rst_flags_a", {29'd0, dv_a, pe_a, se_a}, 32'd0);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_pdata_b", {27'd0, p_data_b}, 32'd0);
        check("rst_busy_b", {31'd0, busy_b}, 32'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Odd parity frame from the line pattern.
        par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b0; prescale = 6'd8;
        frame_raw(16'h048A, 11, 8, 1'b0, 3'b100, 9'h045);
        repeat (12) @(negedge CLK);

        // Even parity; config is disturbed mid-frame and must be ignored.
        par_typ = 1'b0;
        fork
            frame_raw(16'h07AC, 11, 8, 1'b0, 3'b100, 9'h0D6);
            begin
                repeat (20) @(negedge CLK);
                par_typ  = 1'b1;
                prescale = 6'd12;
                stop2    = 1'b1;
            end
        join
        par_typ = 1'b0; prescale = 6'd8; stop2 = 1'b0;
        repeat (12) @(negedge CLK);
        frame(9'h0D6, 8, 8, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        repeat (12) @(negedge CLK);
        check("pdata_hold_after_perr", {24'd0, p_data_a}, 32'h0D6);

        // Two stop bits, the second one bad, then a clean frame.
        frame(9'h0A5, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
        rx_a = 1'b1;
        repeat (32) @(negedge CLK);
        frame(9'h03C, 8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        repeat (20) @(negedge CLK);
        check("pdata_3c", {24'd0, p_data_a}, 32'h03C);

        // Start glitch of two clocks.
        par_en = 1'b0; stop2 = 1'b0; prescale = 6'd8;
        rx_a = 1'b0;
        repeat (1 + SYNC_LAT) @(negedge CLK);
        check("glitch_busy_hi", {31'd0, busy_a}, 32'd1);
        @(negedge CLK);
        rx_a = 1'b1;
        repeat (16) @(negedge CLK);
        check("glitch_busy_lo", {31'd0, busy_a}, 32'd0);
        frame(9'h05A, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        repeat (12) @(negedge CLK);

        // 5-bit instance, back-to-back frames with a single stop bit.
        frame(9'h015, 5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        frame(9'h00A, 5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        repeat (12) @(negedge CLK);
        check("b_pdata_last", {27'd0, p_data_b}, 32'h00A);

        // Reset in the middle of the data bits.
        drive_bits(16'h0002, 4, 8, 1'b0);
        #2;
        RST  = 1'b1;
        rx_a = 1'b1;
        #1;
        check("midrst_pdata", {24'd0, p_data_a}, 32'd0);
        check("midrst_flags", {29'd0, dv_a, pe_a, se_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (24) @(negedge CLK);
        check("postrst_busy", {31'd0, busy_a}, 32'd0);
        frame(9'h081, 8, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        repeat (12) @(negedge CLK);

        // Prescale below 4 disables reception.
        prescale = 6'd3;
        rx_a = 1'b0;
        repeat (10) @(negedge CLK);
        check("disabled_busy", {31'd0, busy_a}, 32'd0);
        rx_a = 1'b1;
        repeat (4) @(negedge CLK);
        prescale = 6'd8;
        repeat (4) @(negedge CLK);

        for (int i = 0; i < 2000 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge CLK);
        check("sb_a_left", 32'(q_a.size()), 32'd0);
        check("sb_b_left", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
